minibyte_regfile: RTL and testbench

Parametrised register file for the MiniByte CPU datapath, successor to the 8-entry single-port register RAM. It has one write port and two independent registered read ports, so the ALU can fetch both operands in one cycle. It also provides a write-first bypass and a hardware clear sweep with a busy indication. The output bus is never tri-stated.

---
 rtl/minibyte_regfile.sv | 172 +++++++++++++++++
 tb/tb_minibyte_regfile.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/minibyte_regfile.sv
// ---------------------------------------------------------------------------
// minibyte_regfile
//
// Register file for the MiniByte CPU datapath: one write port, two
// independent registered read ports (A/B), write-first same-cycle bypass and
// a hardware clear sweep that zeroes every entry while busy_out is high.
// The read data buses are always driven.
//
// Optional feature macro: MINIBYTE_REGFILE_PARITY_EN
//   When defined, each entry carries an even-parity bit, pinj_in inverts the
//   stored parity bit on a write, and par_err_out flags a parity failure on
//   either read port (registered alongside rdata_*).
//
// Parameters:
//   DATA_W        entry width in bits (>= 1)
//   ADDR_W        address width; DEPTH = 2**ADDR_W
//
// Ports:
//   clk_in        clock, rising edge
//   rst_in        asynchronous active-low reset
//   en_in         block enable, gates reads and writes
//   we_in         write request (qualified by en_in)
//   waddr_in      write address
//   wdata_in      write data
//   raddr_a_in    read port A address
//   raddr_b_in    read port B address
//   clr_in        start clear sweep (sampled in IDLE)
//   pinj_in       parity-inject hook (parity build only)
//   rdata_a_out   registered read data, port A
//   rdata_b_out   registered read data, port B
//   rvalid_out    one-cycle pulse when rdata_* were updated
//   busy_out      clear sweep in progress
//   par_err_out   parity error on last read (parity build only)
//
// State table:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | normal operation, reads/writes accepted when en_in=1
//   ST_CLEAR | sweeping entry[idx] to zero, one entry per edge; ops dropped
// ---------------------------------------------------------------------------
module minibyte_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              en_in,
    input  logic              we_in,
    input  logic [ADDR_W-1:0] waddr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [ADDR_W-1:0] raddr_a_in,
    input  logic [ADDR_W-1:0] raddr_b_in,
    input  logic              clr_in,
`ifdef MINIBYTE_REGFILE_PARITY_EN
    input  logic              pinj_in,
    output logic              par_err_out,
`endif
    output logic [DATA_W-1:0] rdata_a_out,
    output logic [DATA_W-1:0] rdata_b_out,
    output logic              rvalid_out,
    output logic              busy_out
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

`ifdef MINIBYTE_REGFILE_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [MEM_W-1:0]  mem [DEPTH];

    logic              rd_en;
    logic              wr_en;
    logic              byp_a;
    logic              byp_b;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  mem_a;
    logic [MEM_W-1:0]  mem_b;

    // A clear request in the same cycle as a write wins, so the write (and
    // therefore its bypass) is suppressed; the read still completes.
    assign rd_en = (state == ST_IDLE) && en_in;
    assign wr_en = rd_en && we_in && !clr_in;
    assign byp_a = wr_en && (raddr_a_in == waddr_in);
    assign byp_b = wr_en && (raddr_b_in == waddr_in);
    assign mem_a = mem[raddr_a_in];
    assign mem_b = mem[raddr_b_in];

`ifdef MINIBYTE_REGFILE_PARITY_EN
    // Stored word is {parity, data}; an intact entry has even overall parity.
    assign wr_word = {(^wdata_in) ^ pinj_in, wdata_in};
`else
    assign wr_word = wdata_in;
`endif

    // Storage: sweep has priority over writes (writes are blocked in CLEAR
    // anyway via rd_en).
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == ST_CLEAR) begin
            mem[idx] <= '0;
        end else if (wr_en) begin
            mem[waddr_in] <= wr_word;
        end
    end

    // Control FSM with registered read outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= ST_IDLE;
            idx         <= '0;
            rdata_a_out <= '0;
            rdata_b_out <= '0;
            rvalid_out  <= 1'b0;
            busy_out    <= 1'b0;
`ifdef MINIBYTE_REGFILE_PARITY_EN
            par_err_out <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    rvalid_out <= en_in;
                    if (en_in) begin
                        rdata_a_out <= byp_a ? wdata_in : mem_a[DATA_W-1:0];
                        rdata_b_out <= byp_b ? wdata_in : mem_b[DATA_W-1:0];
                    end
`ifdef MINIBYTE_REGFILE_PARITY_EN
                    // Bypassed data never went through storage, so it cannot
                    // carry a parity fault.
                    par_err_out <= en_in &&
                                   ((!byp_a && (^mem_a)) || (!byp_b && (^mem_b)));
`endif
                    if (clr_in) begin
                        state    <= ST_CLEAR;
                        busy_out <= 1'b1;
                        idx      <= '0;
                    end
                end
                ST_CLEAR: begin
                    rvalid_out <= 1'b0;
`ifdef MINIBYTE_REGFILE_PARITY_EN
                    par_err_out <= 1'b0;
`endif
                    // Natural overflow returns idx to 0 on the exit edge.
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state    <= ST_IDLE;
                        busy_out <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minibyte_regfile.sv
module tb_minibyte_regfile;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] wa = '0;
    logic [DATA_W-1:0] wd = '0;
    logic [ADDR_W-1:0] ra = '0;
    logic [ADDR_W-1:0] rb = '0;
    logic              clr = 1'b0;
    logic              pinj = 1'b0;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              rvalid;
    logic              busy;
    logic              par_err;

    int tests = 0;
    int fails = 0;

    minibyte_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_in      (clk),
        .rst_in      (rst_n),
        .en_in       (en),
        .we_in       (we),
        .waddr_in    (wa),
        .wdata_in    (wd),
        .raddr_a_in  (ra),
        .raddr_b_in  (rb),
        .clr_in      (clr),
`ifdef MINIBYTE_REGFILE_PARITY_EN
        .pinj_in     (pinj),
        .par_err_out (par_err),
`endif
        .rdata_a_out (rdata_a),
        .rdata_b_out (rdata_b),
        .rvalid_out  (rvalid),
        .busy_out    (busy)
    );

`ifndef MINIBYTE_REGFILE_PARITY_EN
    assign par_err = 1'b0;
`endif

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int          m_mem [DEPTH];
    bit          m_par [DEPTH];   // stored parity bit
    int          m_busy_left;     // sweep edges still to come
    int          m_ra, m_rb;
    bit          m_rvalid, m_perr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = 0;
                m_par[i] = 0;
            end
            m_busy_left = 0;
            m_ra = 0; m_rb = 0; m_rvalid = 0; m_perr = 0;
        end else if (m_busy_left > 0) begin
            m_mem[DEPTH - m_busy_left] = 0;
            m_par[DEPTH - m_busy_left] = 0;
            m_busy_left--;
            m_rvalid = 0;
            m_perr = 0;
        end else begin
            bit wr, hit_a, hit_b, ea, eb;
            wr = en && we && !clr;
            hit_a = wr && (ra == wa);
            hit_b = wr && (rb == wa);
            m_rvalid = en;
            m_perr = 0;
            if (en) begin
                m_ra = hit_a ? int'(wd) : m_mem[ra];
                m_rb = hit_b ? int'(wd) : m_mem[rb];
                ea = !hit_a && (m_par[ra] != ^(m_mem[ra][DATA_W-1:0]));
                eb = !hit_b && (m_par[rb] != ^(m_mem[rb][DATA_W-1:0]));
`ifdef MINIBYTE_REGFILE_PARITY_EN
                m_perr = ea || eb;
`endif
            end
            if (wr) begin
                m_mem[wa] = int'(wd);
                m_par[wa] = (^wd) ^ pinj;
            end
            if (clr) m_busy_left = DEPTH;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", int'(busy), int'(m_busy_left > 0));
            chk("rvalid", int'(rvalid), int'(m_rvalid));
            chk("rdata_a", int'(rdata_a), m_ra);
            chk("rdata_b", int'(rdata_b), m_rb);
            chk("par_err", int'(par_err), int'(m_perr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit e, input bit w, input int a, input int d,
                       input int xa, input int xb, input bit c, input bit p);
        @(negedge clk);
        en = e; we = w; wa = a[ADDR_W-1:0]; wd = d[DATA_W-1:0];
        ra = xa[ADDR_W-1:0]; rb = xb[ADDR_W-1:0]; clr = c; pinj = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        en = 0; we = 0; clr = 0; pinj = 0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_rdata_a", int'(rdata_a), 0);
        chk("rst_rdata_b", int'(rdata_b), 0);
        chk("rst_rvalid", int'(rvalid), 0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        // Reset state
        #12;
        chk("reset_busy", int'(busy), 0);
        chk("reset_rvalid", int'(rvalid), 0);
        chk("reset_rdata_a", int'(rdata_a), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Read after reset at 0 and 7
        cyc(1, 0, 0, 0, 0, 7, 0, 0);
        chk("rd0_a", int'(rdata_a), 8'h00);
        chk("rd7_b", int'(rdata_b), 8'h00);
        chk("rd_rvalid", int'(rvalid), 1);
        chk("rd_busy", int'(busy), 0);
        idle();
        chk("rvalid_pulse", int'(rvalid), 0);

        // Write then read
        cyc(1, 1, 3, 8'hA5, 0, 0, 0, 0);
        cyc(1, 1, 6, 8'h5A, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 3, 6, 0, 0);
        chk("wr_rd_a", int'(rdata_a), 8'hA5);
        chk("wr_rd_b", int'(rdata_b), 8'h5A);

        // Same-cycle bypass on both ports
        cyc(1, 1, 2, 8'h3C, 2, 2, 0, 0);
        chk("byp_a", int'(rdata_a), 8'h3C);
        chk("byp_b", int'(rdata_b), 8'h3C);

        // Fill, clear, write during busy is dropped
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, i, 8'hFF, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            if (cnt == 1) cyc(1, 1, 0, 8'h11, 0, 0, 0, 0);
            else idle();
        end
        chk("busy_len", cnt, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, 0, 0, 0, i, DEPTH - 1 - i, 0, 0);
            chk("after_clr_a", int'(rdata_a), 0);
            chk("after_clr_b", int'(rdata_b), 0);
        end

        // Reset in the middle of a sweep
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, i, 8'hFF, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 7, 7, 1, 0);
        chk("clr_read_a", int'(rdata_a), 8'hFF);
        for (int i = 0; i < 3; i++) idle();
        chk("mid_busy", int'(busy), 1);
        mid_reset();
        cyc(1, 0, 0, 0, 7, 5, 0, 0);
        chk("post_rst_rd7", int'(rdata_a), 0);
        chk("post_rst_busy", int'(busy), 0);

`ifdef MINIBYTE_REGFILE_PARITY_EN
        cyc(1, 1, 4, 8'h01, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 4, 0, 0, 0);
        chk("pinj_err", int'(par_err), 1);
        cyc(1, 1, 4, 8'h01, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 4, 0, 0, 0);
        chk("pinj_clean", int'(par_err), 0);
`endif

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                mid_reset();
            end else begin
                cyc($urandom_range(0, 99) < 85,
                    $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, DEPTH - 1)),
                    int'($urandom_range(0, 255)),
                    int'($urandom_range(0, DEPTH - 1)),
                    int'($urandom_range(0, DEPTH - 1)),
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 7) == 0);
            end
        end
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
